// File: rtl/appr_error_monitor.sv
// appr_error_monitor
// ------------------
// Error-statistics collector for an approximate adder under test. Each
// accepted sample pair (approximate sum with carry-out, exact sum with
// carry-out) goes through a two-stage pipeline:
//   - stage 1 forms the signed error and its magnitude;
//   - stage 2 squares the magnitude.
// The accumulators then take count, signed error sum, squared-error sum,
// maximum magnitude and nonzero-error count. A host derives mean, variance
// and error rate from these values.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   start       pulse: clear statistics and run `target` samples (IDLE/DONE only)
//   abort       pulse: stop accepting and drain the pipeline (RUN only)
//   target      sample count for the run, latched on start
//   in_valid    sample pair valid
//   in_ready    sample accepted this cycle when in_valid is also high
//   appr_sum    {Cout,S} from the approximate adder
//   exact_sum   {Cout,S} reference
//   busy, done  run/drain in progress; run finished and results stable
//   count, err_sum, sq_sum, max_abs, nz_count   statistics
//   ovf         sticky wrap flag for err_sum / sq_sum
module appr_error_monitor #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32,
  parameter int ACC_W = 64,
  parameter int SQ_W  = 96
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   target,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH:0]     appr_sum,
  input  logic [WIDTH:0]     exact_sum,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  output logic [ACC_W-1:0]   err_sum,
  output logic [SQ_W-1:0]    sq_sum,
  output logic [WIDTH+1:0]   max_abs,
  output logic [CNT_W-1:0]   nz_count,
  output logic               ovf
);

  localparam int EW = WIDTH + 2;  // signed error width
  localparam int PW = 2 * EW;     // squared error width

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] target_q,   target_d;
  logic [CNT_W-1:0] issued_q,   issued_d;

  logic             v1_q,       v1_d;
  logic [EW-1:0]    e1_q,       e1_d;
  logic [EW-1:0]    a1_q,       a1_d;

  logic             v2_q,       v2_d;
  logic [EW-1:0]    e2_q,       e2_d;
  logic [EW-1:0]    a2_q,       a2_d;
  logic [PW-1:0]    sq2_q,      sq2_d;

  logic [CNT_W-1:0] count_q,    count_d;
  logic [ACC_W-1:0] err_sum_q,  err_sum_d;
  logic [SQ_W-1:0]  sq_sum_q,   sq_sum_d;
  logic [EW-1:0]    max_abs_q,  max_abs_d;
  logic [CNT_W-1:0] nz_count_q, nz_count_d;
  logic             ovf_q,      ovf_d;

  logic             accept;
  logic [ACC_W-1:0] err_add;
  logic [ACC_W-1:0] err_new;
  logic [SQ_W:0]    sq_new;

  assign in_ready = (state_q == S_RUN) && (issued_q < target_q);
  assign accept   = in_valid && in_ready;

  // Pipeline datapath.
  // - Both sums are zero-extended by one bit before subtracting, so the
  //   EW-bit two's-complement difference is exact.
  // - Data registers load every cycle; only the valid bits qualify them.
  always_comb begin
    v1_d  = accept;
    e1_d  = {1'b0, appr_sum} - {1'b0, exact_sum};
    a1_d  = e1_d[EW-1] ? (~e1_d + EW'(1)) : e1_d;
    v2_d  = v1_q;
    e2_d  = e1_q;
    a2_d  = a1_q;
    sq2_d = {{EW{1'b0}}, a1_q} * {{EW{1'b0}}, a1_q};
  end

  // Accumulator arithmetic with wrap detection:
  // - err_sum overflows when the addends share a sign that the result
  //   does not;
  // - sq_sum overflows on a carry out of its top bit.
  always_comb begin
    err_add = {{(ACC_W-EW){e2_q[EW-1]}}, e2_q};
    err_new = err_sum_q + err_add;
    sq_new  = {1'b0, sq_sum_q} + {{(SQ_W+1-PW){1'b0}}, sq2_q};
  end

  // Control FSM and accumulator next-state.
  // A start accepted in IDLE/DONE is assigned last, so its clear wins. In
  // those states the pipeline is already empty, so nothing is lost.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    issued_d   = issued_q;
    count_d    = count_q;
    err_sum_d  = err_sum_q;
    sq_sum_d   = sq_sum_q;
    max_abs_d  = max_abs_q;
    nz_count_d = nz_count_q;
    ovf_d      = ovf_q;

    if (accept) begin
      issued_d = issued_q + CNT_W'(1);
    end

    if (v2_q) begin
      count_d   = count_q + CNT_W'(1);
      err_sum_d = err_new;
      sq_sum_d  = sq_new[SQ_W-1:0];
      if (a2_q > max_abs_q) begin
        max_abs_d = a2_q;
      end
      if (e2_q != '0) begin
        nz_count_d = nz_count_q + CNT_W'(1);
      end
      if (((err_sum_q[ACC_W-1] == err_add[ACC_W-1]) &&
           (err_new[ACC_W-1] != err_sum_q[ACC_W-1])) || sq_new[SQ_W]) begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          target_d   = target;
          issued_d   = '0;
          count_d    = '0;
          err_sum_d  = '0;
          sq_sum_d   = '0;
          max_abs_d  = '0;
          nz_count_d = '0;
          ovf_d      = 1'b0;
          state_d    = (target == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort || (accept && (issued_q + CNT_W'(1) == target_q))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!v1_q && !v2_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset discards the pipeline contents and all statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      issued_q   <= '0;
      v1_q       <= 1'b0;
      e1_q       <= '0;
      a1_q       <= '0;
      v2_q       <= 1'b0;
      e2_q       <= '0;
      a2_q       <= '0;
      sq2_q      <= '0;
      count_q    <= '0;
      err_sum_q  <= '0;
      sq_sum_q   <= '0;
      max_abs_q  <= '0;
      nz_count_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      issued_q   <= issued_d;
      v1_q       <= v1_d;
      e1_q       <= e1_d;
      a1_q       <= a1_d;
      v2_q       <= v2_d;
      e2_q       <= e2_d;
      a2_q       <= a2_d;
      sq2_q      <= sq2_d;
      count_q    <= count_d;
      err_sum_q  <= err_sum_d;
      sq_sum_q   <= sq_sum_d;
      max_abs_q  <= max_abs_d;
      nz_count_q <= nz_count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign count    = count_q;
  assign err_sum  = err_sum_q;
  assign sq_sum   = sq_sum_q;
  assign max_abs  = max_abs_q;
  assign nz_count = nz_count_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/appr_error_monitor.md
Name: appr_error_monitor

Overview:
- Hardware error-statistics collector placed directly downstream of the approximate adder under test (e.g. the 32-bit, 8-LSB-approximated mirror adder).
- Consumes sample pairs: approximate sum with carry-out, and exact sum with carry-out.
- Computes the signed error (approximate minus exact) and accumulates count, error sum, squared-error sum, maximum absolute error and nonzero-error count over a programmed number of samples.
- A host or bench derives mean, variance and error rate from the accumulators.

Parameters:
- WIDTH, 32, adder operand width; each sum input is WIDTH+1 bits including carry-out.
- CNT_W, 32, sample counter and target width.
- ACC_W, 64, signed error-sum accumulator width.
- SQ_W, 96, unsigned squared-error accumulator width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; clears accumulators and begins a run of `target` samples
- abort  in  1  pulse; stops accepting samples and drains the pipeline
- target  in  CNT_W  number of samples; sampled on start
- in_valid  in  1  sample pair valid
- in_ready  out  1  monitor accepts a sample this cycle
- appr_sum  in  WIDTH+1  {Cout,S} from the approximate adder
- exact_sum  in  WIDTH+1  reference sum with carry
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- count  out  CNT_W  samples accumulated
- err_sum  out  ACC_W  signed sum of errors
- sq_sum  out  SQ_W  sum of squared errors
- max_abs  out  WIDTH+2  largest absolute error
- nz_count  out  CNT_W  samples with nonzero error
- ovf  out  1  sticky flag: err_sum or sq_sum wrapped

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs and accumulators are 0; in_ready=0.
  - Pipeline valid bits are cleared.
  - Reset mid-run discards all data.
- States:
  - IDLE: start moves to RUN. If target==0, start moves directly to DONE.
  - RUN: in_ready=1 while issued<target_q. When the last sample is accepted, or abort=1, move to DRAIN.
  - DRAIN: in_ready=0. Move to DONE when both pipeline stages are empty.
  - DONE: done=1; accumulators hold. start re-arms, as from IDLE.
- Priorities:
  - start while in RUN or DRAIN is ignored.
  - abort in IDLE or DONE is ignored.
  - start and abort in the same cycle: start wins in IDLE/DONE; abort wins in RUN.
- start in IDLE/DONE:
  - Clears count, err_sum, sq_sum, max_abs, nz_count, ovf and issued.
  - Latches target into target_q.
- Accept: a sample is accepted when in_valid && in_ready.
- Stage 1 (cycle after accept):
  - e = sign-extended (appr_sum - exact_sum) to WIDTH+2 bits, both operands zero-extended first.
  - a = |e|, with WIDTH+1 unsigned bits significant.
- Stage 2: sq = a*a, 2*(WIDTH+2) bits.
- Accumulate (cycle after stage 2): total latency is 3 cycles from accept to visible count/err_sum/sq_sum update.
  - count += 1.
  - err_sum += sign-extended e.
  - sq_sum += zero-extended sq.
  - max_abs = max(max_abs, a).
  - nz_count += (e != 0).
- Overflow: err_sum and sq_sum wrap modulo 2^ACC_W and 2^SQ_W. Any signed overflow of err_sum or unsigned carry out of sq_sum sets ovf until the next start.
- Throughput: one sample per cycle. There is no back-pressure beyond in_ready gating by target.
- Abort: samples already in the pipeline are still accumulated before DONE.

Test Plan:
- Single-sample run:
  - Stimulus: target=1, appr_sum=0x0_0000_00FF, exact_sum=0x0_0000_0100.
  - Response: err_sum=-1, sq_sum=1, max_abs=1, nz_count=1, count=1, done 4 cycles after accept.
- Mixed-error run:
  - Stimulus: target=4, errors +3, -5, 0, +2 back-to-back.
  - Response: err_sum=0, sq_sum=38, max_abs=5, nz_count=3, count=4; in_ready drops the cycle after the 4th accept.
- Carry-out extremes:
  - Stimulus: target=2; appr=0x1_0000_0000 vs exact=0x0_0000_0000; appr=0x0_0000_0000 vs exact=0x1_FFFF_FFFE.
  - Response: max_abs=0x1_FFFF_FFFE, err_sum=2^32-(2^33-2)=-0xFFFF_FFFE, ovf=0.
- Abort:
  - Stimulus: target=100; 10 samples of error +1, then abort.
  - Response: in_ready=0 after abort, count=10, err_sum=10, done after drain, busy=0.
- target=0, and start ignored while busy:
  - Stimulus: start with target=0.
  - Response: done next cycle, all statistics 0.
  - Stimulus: start mid-RUN.
  - Response: no effect on counters.
- Reset mid-run:
  - Stimulus: assert rst asynchronously with the pipeline full.
  - Response: all outputs 0 immediately, state IDLE; a subsequent start/run behaves normally.
